// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: mode codes, select codes and FSM states.
package alu_pkg;

  localparam logic [1:0] MODE_ARITH = 2'b00;
  localparam logic [1:0] MODE_LOGIC = 2'b01;
  localparam logic [1:0] MODE_MUL   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  localparam logic [3:0] ARITH_A    = 4'h0;
  localparam logic [3:0] ARITH_ADD  = 4'h1;
  localparam logic [3:0] ARITH_SUB  = 4'h2;
  localparam logic [3:0] ARITH_RSUB = 4'h3;
  localparam logic [3:0] ARITH_DBL  = 4'h4;
  localparam logic [3:0] ARITH_DEC  = 4'h5;
  localparam logic [3:0] ARITH_AND  = 4'h6;
  localparam logic [3:0] ARITH_OR   = 4'h7;

  localparam logic [3:0] LOGIC_NOT_A   = 4'h0;
  localparam logic [3:0] LOGIC_NOR     = 4'h1;
  localparam logic [3:0] LOGIC_NA_AND_B = 4'h2;
  localparam logic [3:0] LOGIC_ZERO    = 4'h3;
  localparam logic [3:0] LOGIC_NAND    = 4'h4;
  localparam logic [3:0] LOGIC_NOT_B   = 4'h5;
  localparam logic [3:0] LOGIC_XOR     = 4'h6;
  localparam logic [3:0] LOGIC_A_AND_NB = 4'h7;
  localparam logic [3:0] LOGIC_NA_OR_B = 4'h8;
  localparam logic [3:0] LOGIC_XNOR    = 4'h9;
  localparam logic [3:0] LOGIC_B       = 4'hA;
  localparam logic [3:0] LOGIC_AND     = 4'hB;
  localparam logic [3:0] LOGIC_ONES    = 4'hC;
  localparam logic [3:0] LOGIC_A_OR_NB = 4'hD;
  localparam logic [3:0] LOGIC_OR      = 4'hE;
  localparam logic [3:0] LOGIC_A       = 4'hF;

  localparam logic [3:0] MUL_UNSIGNED = 4'h0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per clock, WIDTH steps.
// done is asserted in the cycle the final product is presented on product; after
// the last step the product is held until the parent takes it.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               take,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [CW-1:0]      cnt;
  logic               active;

  assign acc_step = acc + (mplier[0] ? mcand : '0);

  // Latch operands on start, then add-and-shift once per cycle until the counter expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
      active <= 1'b1;
    end else begin
      if (take) begin
        active <= 1'b0;
      end
      if (active && (cnt != '0)) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end
    end
  end

  // Final product is the in-flight step on the last count, or the held accumulator afterwards.
  always_comb begin
    done    = active && (cnt <= CW'(1));
    product = (cnt == '0) ? acc : acc_step;
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle arithmetic/logic ops and an
// optional multi-cycle unsigned multiply, results held in a registered output stage.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [3:0]       select,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             compare,
  output logic             err
);

  state_t state, state_nxt;

  logic               res_free;
  logic               accept;
  logic               is_mul_op;
  logic               mul_start;
  logic               mul_take;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               cmp_lat;

  logic [WIDTH-1:0]   op1, op2;
  logic               ovf_chk;
  logic [WIDTH:0]     sum;

  logic [WIDTH-1:0]   c_out;
  logic               c_carry, c_ovf, c_zero, c_cmp, c_err;

  assign res_free  = !out_valid || out_ready;
  assign is_mul_op = (MUL_EN != 0) && (mode == MODE_MUL) && (select == MUL_UNSIGNED);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (in_a),
    .b       (in_b),
    .take    (mul_take),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Adder operand selection for the arithmetic codes; ovf_chk marks codes with signed overflow.
  always_comb begin
    op1     = '0;
    op2     = '0;
    ovf_chk = 1'b0;
    case (select)
      ARITH_A:    begin op1 = in_a;        op2 = '0;                       end
      ARITH_ADD:  begin op1 = in_a;        op2 = in_b;        ovf_chk = 1'b1; end
      ARITH_SUB:  begin op1 = in_a;        op2 = ~in_b;       ovf_chk = 1'b1; end
      ARITH_RSUB: begin op1 = ~in_a;       op2 = in_b;        ovf_chk = 1'b1; end
      ARITH_DBL:  begin op1 = in_a;        op2 = in_a;        ovf_chk = 1'b1; end
      ARITH_DEC:  begin op1 = in_a;        op2 = '1;          ovf_chk = 1'b1; end
      ARITH_AND:  begin op1 = in_a & in_b; op2 = '0;                       end
      ARITH_OR:   begin op1 = in_a | in_b; op2 = '0;                       end
      default:    begin op1 = '0;          op2 = '0;                       end
    endcase
  end

  assign sum = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, carry_in};

  // Single-cycle result and flags; reserved encodings force a zero result with err set.
  always_comb begin
    c_out   = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    c_err   = 1'b0;
    case (mode)
      MODE_ARITH: begin
        if (select[3]) begin
          c_err = 1'b1;
        end else begin
          c_out   = sum[WIDTH-1:0];
          c_carry = sum[WIDTH];
          c_ovf   = ovf_chk && (op1[WIDTH-1] == op2[WIDTH-1]) &&
                    (sum[WIDTH-1] != op1[WIDTH-1]);
        end
      end
      MODE_LOGIC: begin
        case (select)
          LOGIC_NOT_A:    c_out = ~in_a;
          LOGIC_NOR:      c_out = ~(in_a | in_b);
          LOGIC_NA_AND_B: c_out = ~in_a & in_b;
          LOGIC_ZERO:     c_out = '0;
          LOGIC_NAND:     c_out = ~(in_a & in_b);
          LOGIC_NOT_B:    c_out = ~in_b;
          LOGIC_XOR:      c_out = in_a ^ in_b;
          LOGIC_A_AND_NB: c_out = in_a & ~in_b;
          LOGIC_NA_OR_B:  c_out = ~in_a | in_b;
          LOGIC_XNOR:     c_out = ~(in_a ^ in_b);
          LOGIC_B:        c_out = in_b;
          LOGIC_AND:      c_out = in_a & in_b;
          LOGIC_ONES:     c_out = '1;
          LOGIC_A_OR_NB:  c_out = in_a | ~in_b;
          LOGIC_OR:       c_out = in_a | in_b;
          default:        c_out = in_a;
        endcase
      end
      default: begin
        // Multiply with an unsupported select, multiply disabled, or mode 11.
        c_err = 1'b1;
      end
    endcase
    c_zero = !c_err && (c_out == '0);
    c_cmp  = !c_err && (in_a == in_b);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: enter BUSY on an accepted multiply, leave once the product is stored.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul_op)  state_nxt = ST_BUSY;
      ST_BUSY: if (mul_done && res_free) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake and multiplier control.
  always_comb begin
    in_ready  = (state == ST_IDLE) && res_free;
    accept    = in_valid && in_ready;
    mul_start = accept && is_mul_op;
    mul_take  = (state == ST_BUSY) && mul_done && res_free;
  end

  // Result register: new single-cycle result, finished product, or drain on output transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_out    <= '0;
      alu_out_hi <= '0;
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
      compare    <= 1'b0;
      err        <= 1'b0;
      cmp_lat    <= 1'b0;
    end else begin
      if (mul_start) begin
        cmp_lat <= (in_a == in_b);
      end
      if (accept && !is_mul_op) begin
        out_valid  <= 1'b1;
        alu_out    <= c_out;
        alu_out_hi <= '0;
        carry_out  <= c_carry;
        overflow   <= c_ovf;
        zero       <= c_zero;
        compare    <= c_cmp;
        err        <= c_err;
      end else if (mul_take) begin
        out_valid  <= 1'b1;
        alu_out    <= mul_prod[WIDTH-1:0];
        alu_out_hi <= mul_prod[2*WIDTH-1:WIDTH];
        carry_out  <= |mul_prod[2*WIDTH-1:WIDTH];
        overflow   <= 1'b0;
        zero       <= (mul_prod == '0);
        compare    <= cmp_lat;
        err        <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [3:0]  select;
  logic        carry_in;
  logic [15:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] alu_out, alu_out_hi;
  logic        carry_out, overflow, zero, compare, err;

  int n_assert = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(16), .MUL_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .select     (select),
    .carry_in   (carry_in),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_out    (alu_out),
    .alu_out_hi (alu_out_hi),
    .carry_out  (carry_out),
    .overflow   (overflow),
    .zero       (zero),
    .compare    (compare),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] m, input logic [3:0] s, input logic c,
                       input logic [15:0] a, input logic [15:0] b);
    mode = m; select = s; carry_in = c; in_a = a; in_b = b;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic busy_ready_seen;
    logic spurious;
    logic [15:0] a_v;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; select = 4'h0; carry_in = 1'b0; in_a = '0; in_b = '0;
    tick(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_alu_out_hi", alu_out_hi, 0);
    chk("rst_flags", {carry_out, overflow, zero, compare, err}, 0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_in_ready", in_ready, 1);

    // FFFF + 0001 wraps to zero with carry.
    issue(2'b00, 4'h1, 1'b0, 16'hFFFF, 16'h0001);
    chk("add_wrap_valid", out_valid, 1);
    chk("add_wrap_out", alu_out, 16'h0000);
    chk("add_wrap_carry", carry_out, 1);
    chk("add_wrap_zero", zero, 1);
    chk("add_wrap_ovf", overflow, 0);

    // 7FFF - FFFF overflows to 8000.
    issue(2'b00, 4'h2, 1'b1, 16'h7FFF, 16'hFFFF);
    chk("sub_ovf_out", alu_out, 16'h8000);
    chk("sub_ovf_ovf", overflow, 1);
    chk("sub_ovf_carry", carry_out, 0);
    // 5 - 7 borrows.
    issue(2'b00, 4'h2, 1'b1, 16'h0005, 16'h0007);
    chk("sub_borrow_out", alu_out, 16'hFFFE);
    chk("sub_borrow_carry", carry_out, 0);

    issue(2'b01, 4'h6, 1'b0, 16'hF0F0, 16'hFF00);
    chk("xor_out", alu_out, 16'h0FF0);
    chk("xor_cmp", compare, 0);
    issue(2'b01, 4'h3, 1'b0, 16'h1234, 16'h1234);
    chk("lzero_out", alu_out, 16'h0000);
    chk("lzero_zero", zero, 1);
    chk("lzero_cmp", compare, 1);

    // Decrement: 0000-1 no carry; 8000-1 signed overflow with carry.
    issue(2'b00, 4'h5, 1'b0, 16'h0000, 16'h0000);
    chk("dec0_out", alu_out, 16'hFFFF);
    chk("dec0_flags", {carry_out, overflow}, 2'b00);
    issue(2'b00, 4'h5, 1'b0, 16'h8000, 16'h0000);
    chk("dec8000_out", alu_out, 16'h7FFF);
    chk("dec8000_flags", {carry_out, overflow}, 2'b11);
    issue(2'b01, 4'hC, 1'b0, 16'h0000, 16'h0000);
    chk("ones_out", alu_out, 16'hFFFF);
    issue(2'b01, 4'h2, 1'b0, 16'h00FF, 16'h0F0F);
    chk("nab_out", alu_out, 16'h0F00);
    issue(2'b00, 4'h6, 1'b1, 16'h00FF, 16'h0F0F);
    chk("and_cin_out", alu_out, 16'h0010);
    issue(2'b00, 4'h8, 1'b0, 16'h1111, 16'h2222);
    chk("arith_rsvd_out", alu_out, 16'h0000);
    chk("arith_rsvd_err", err, 1);

    // Back-to-back adds at full throughput.
    mode = 2'b00; select = 4'h1; carry_in = 1'b0; in_b = 16'h0010;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_v = 16'h0101 * 16'(i + 1);
      in_a = a_v;
      tick(1);
      chk("b2b_valid", out_valid, 1);
      chk("b2b_out", alu_out, a_v + 16'h0010);
    end
    in_valid = 1'b0;
    tick(1);
    chk("drain_valid", out_valid, 0);

    // Backpressure holds result and blocks accepts.
    out_ready = 1'b0;
    issue(2'b00, 4'h1, 1'b0, 16'h0003, 16'h0004);
    chk("bp_first_out", alu_out, 16'h0007);
    mode = 2'b00; select = 4'h1; in_a = 16'h0005; in_b = 16'h0005; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("bp_hold_out", alu_out, 16'h0007);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick(1);
    in_valid = 1'b0;
    chk("bp_release_out", alu_out, 16'h000A);
    tick(1);

    // Multiply 1234 * 0100 = 0012_3400 after 16 busy cycles.
    issue(2'b10, 4'h0, 1'b0, 16'h1234, 16'h0100);
    chk("mul_in_ready_busy", in_ready, 0);
    n = 0;
    busy_ready_seen = 1'b0;
    while (!out_valid && n < 40) begin
      tick(1);
      n++;
      if (!out_valid && in_ready) busy_ready_seen = 1'b1;
    end
    chk("mul_latency", n, 16);
    chk("mul_ready_low", busy_ready_seen, 0);
    chk("mul_lo", alu_out, 16'h3400);
    chk("mul_hi", alu_out_hi, 16'h0012);
    chk("mul_carry", carry_out, 1);
    tick(1);

    // Multiply finishing into a blocked output stage.
    out_ready = 1'b0;
    issue(2'b10, 4'h0, 1'b0, 16'h0003, 16'h0005);
    tick(20);
    chk("mulbp_valid", out_valid, 1);
    chk("mulbp_lo", alu_out, 16'h000F);
    chk("mulbp_hi_carry", {alu_out_hi, 15'b0, carry_out}, 32'h0);
    chk("mulbp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick(1);
    chk("mulbp_drain", out_valid, 0);

    issue(2'b10, 4'h1, 1'b0, 16'h0003, 16'h0005);
    chk("mul_rsvd_err", err, 1);
    chk("mul_rsvd_out", alu_out, 16'h0000);
    tick(1);

    // Reset during BUSY cycle 5 aborts the multiply.
    issue(2'b10, 4'h0, 1'b0, 16'hFFFF, 16'hFFFF);
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out", alu_out, 16'h0000);
    spurious = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (out_valid) spurious = 1'b1;
    end
    chk("abort_no_result", spurious, 0);

    issue(2'b11, 4'h0, 1'b0, 16'h0005, 16'h0005);
    chk("mode3_valid", out_valid, 1);
    chk("mode3_out", alu_out, 16'h0000);
    chk("mode3_err", err, 1);
    chk("mode3_carry", carry_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
